matrix_ctrl: RTL
================

Name: matrix_ctrl

Overview:
Command sequencer for the 1024x1024 x 32-bit matrix datapath (16 distributed RAMs of 64K words each, asynchronous read, synchronous write).
Accepts single-word read/write, row-burst read and row-fill commands over a valid/ready interface.
Decodes row/col into RAM select plus word address, and drives the datapath's ram_sel/a/din/we.
Returns read data over a valid/ready stream with backpressure.

Parameters:
ROW_W, 10, row index width (1024 rows)
COL_W, 10, column index width (1024 columns)
DATA_W, 32, matrix element width
NRAM, 16, number of RAM banks (one-hot select/we width)

Ports:
CLK  input  1  clock, all logic on rising edge
RST_L  input  1  reset, asynchronous assert, active-low
cmd_valid  input  1  command present
cmd_ready  output  1  controller accepts command this cycle
cmd_op  input  2  00 read word, 01 write word, 10 row-burst read, 11 row fill
cmd_row  input  ROW_W  target row
cmd_col  input  COL_W  target column (ignored for ops 10/11)
cmd_wdata  input  DATA_W  write/fill value
rd_valid  output  1  rd_data valid
rd_ready  input  1  consumer accepts rd_data
rd_data  output  DATA_W  read result
rd_last  output  1  final beat of a read (always 1 for op 00; col 1023 beat for op 10)
busy  output  1  state != IDLE
ram_sel  output  NRAM  one-hot bank select to datapath output mux
a  output  16  word address within bank
din  output  DATA_W  write data to datapath
we  output  NRAM  one-hot write enable
dout  input  DATA_W  datapath read data (combinational from ram_sel/a)

Behaviour:
- Reset (RST_L low, asynchronous): state=IDLE, ram_sel=16'h0001, a=0, din=0, we=0, rd_valid=0, rd_data=0, rd_last=0, busy=0. Any in-flight command is abandoned; no write pulse survives reset.
- Address map: bank = row[9:6], a = {row[5:0], col}. ram_sel = one-hot(bank); we uses the same one-hot when writing.
- cmd_ready = (state==IDLE) && !rd_valid. The handshake occurs on cmd_valid && cmd_ready; command fields are sampled only then.
- ram_sel, a, din and we are registered outputs. ram_sel stays at the last driven bank when idle, never all-zero.
- States: IDLE, WR, RD, BURST, FILL.
- IDLE -> WR/RD/BURST/FILL on accept.
- WR (1 cycle): we=one-hot(bank), a and din valid -> IDLE. The write commits on the edge ending WR. Accept-to-commit is 2 edges.
- RD: address is driven in the cycle after accept. rd_data<=dout and rd_valid<=1 with rd_last=1 at the end of that cycle -> IDLE. The next command is accepted only after the rd handshake.
- BURST: col counter starts at 0, and the address is driven from the counter. Each cycle in which (!rd_valid || rd_ready) holds, rd_data<=dout, rd_valid<=1, rd_last<=(col==1023), and col increments. Throughput is 1 beat/cycle when rd_ready is held high. Under stall, the address is held and no beat is lost or duplicated. The beat with col==1023 loads -> IDLE. rd_valid stays high until consumed.
- FILL: we asserted for 1024 consecutive cycles, col 0..1023, din=cmd_wdata -> IDLE. Duration is exactly 1024 cycles, with no backpressure.
- rd_valid clears on rd_ready when no new beat loads the same cycle. rd_ready is ignored while rd_valid=0.
- The column counter stops at 1023 and never wraps into the next row. Bank crossings happen only between rows, never inside a burst.
- Writes and reads never overlap. we=0 in every state except WR/FILL.

Test Plan:
- Reset mid-FILL (after 100 cycles) -> we=0 immediately (asynchronous), state IDLE. Row cols 0..99 hold the fill value, cols 100..1023 unchanged.
- Write (row 5, col 7, 32'hDEADBEEF), then read the same location -> we=16'h0001 for 1 cycle with a=16'h1407. Read returns 32'hDEADBEEF, rd_last=1, cmd_ready low until the rd handshake.
- Write row 1023 col 1023 = 32'h12345678 -> we=16'h8000, a=16'hFFFF. Readback matches. Row 64 col 0 maps to ram_sel=16'h0002, a=0.
- Fill row 200 with 32'hA5A5A5A5, then burst-read row 200 with rd_ready=1 -> exactly 1024 beats on consecutive cycles, all 32'hA5A5A5A5, rd_last only on beat 1024.
- Burst-read a row preloaded with data=col, with rd_ready toggling randomly -> beats are 0..1023 in order, with no drop or duplicate, and rd_data is held stable while stalled.
- Back-to-back writes with cmd_valid held high -> one accept every 2 cycles. busy=1 in WR, cmd_ready=0 during FILL/BURST.

Source files
------------

// File: rtl/matrix_ctrl.sv
// Command sequencer for the 1024x1024 x 32-bit banked matrix datapath.
// Decodes row/col into bank select and word address; streams read data back with backpressure.
module matrix_ctrl #(
    parameter int ROW_W  = 10,
    parameter int COL_W  = 10,
    parameter int DATA_W = 32,
    parameter int NRAM   = 16
) (
    input  logic                                    CLK,
    input  logic                                    RST_L,
    input  logic                                    cmd_valid,
    output logic                                    cmd_ready,
    input  logic [1:0]                              cmd_op,
    input  logic [ROW_W-1:0]                        cmd_row,
    input  logic [COL_W-1:0]                        cmd_col,
    input  logic [DATA_W-1:0]                       cmd_wdata,
    output logic                                    rd_valid,
    input  logic                                    rd_ready,
    output logic [DATA_W-1:0]                       rd_data,
    output logic                                    rd_last,
    output logic                                    busy,
    output logic [NRAM-1:0]                         ram_sel,
    output logic [ROW_W+COL_W-$clog2(NRAM)-1:0]     a,
    output logic [DATA_W-1:0]                       din,
    output logic [NRAM-1:0]                         we,
    input  logic [DATA_W-1:0]                       dout
);

    localparam int BANK_W  = $clog2(NRAM);
    localparam int ROWLO_W = ROW_W - BANK_W;
    localparam int A_W     = ROWLO_W + COL_W;

    localparam logic [1:0]        OP_RD    = 2'b00;
    localparam logic [1:0]        OP_WR    = 2'b01;
    localparam logic [1:0]        OP_BURST = 2'b10;
    localparam logic [1:0]        OP_FILL  = 2'b11;
    localparam logic [COL_W-1:0]  COL_ZERO = {COL_W{1'b0}};
    localparam logic [COL_W-1:0]  COL_ONE  = {{(COL_W-1){1'b0}}, 1'b1};
    localparam logic [COL_W-1:0]  COL_LAST = {COL_W{1'b1}};
    localparam logic [NRAM-1:0]   SEL_RST  = {{(NRAM-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR    = 3'd1,
        ST_RD    = 3'd2,
        ST_BURST = 3'd3,
        ST_FILL  = 3'd4
    } state_t;

    function automatic logic [NRAM-1:0] bank_onehot(input logic [ROW_W-1:0] row);
        logic [NRAM-1:0] oh;
        oh = {NRAM{1'b0}};
        oh[row[ROW_W-1 -: BANK_W]] = 1'b1;
        return oh;
    endfunction

    function automatic logic [A_W-1:0] word_addr(input logic [ROW_W-1:0] row,
                                                 input logic [COL_W-1:0] col);
        return {row[ROWLO_W-1:0], col};
    endfunction

    state_t              state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [NRAM-1:0]     ram_sel_q, ram_sel_d;
    logic [A_W-1:0]      a_q, a_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic [NRAM-1:0]     we_q, we_d;
    logic                rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_last_q, rd_last_d;

    logic                cmd_ready_s;
    logic                accept_s;
    logic                beat_load_s;
    logic [COL_W-1:0]    col_next_s;

    assign cmd_ready_s = (state_q == ST_IDLE) && !rd_valid_q;
    assign accept_s    = cmd_valid && cmd_ready_s;
    // A burst beat loads whenever the output register is empty or being drained.
    assign beat_load_s = (state_q == ST_BURST) && (!rd_valid_q || rd_ready);
    assign col_next_s  = col_q + COL_ONE;

    // Next-state and registered-output computation for the command sequencer.
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        ram_sel_d  = ram_sel_q;
        a_d        = a_q;
        din_d      = din_q;
        we_d       = {NRAM{1'b0}};
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        rd_last_d  = rd_last_q;

        if (rd_valid_q && rd_ready) begin
            rd_valid_d = 1'b0;
        end else begin
            rd_valid_d = rd_valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    ram_sel_d = bank_onehot(cmd_row);
                    col_d     = COL_ZERO;
                    case (cmd_op)
                        OP_RD: begin
                            a_d     = word_addr(cmd_row, cmd_col);
                            state_d = ST_RD;
                        end
                        OP_WR: begin
                            a_d     = word_addr(cmd_row, cmd_col);
                            din_d   = cmd_wdata;
                            we_d    = bank_onehot(cmd_row);
                            state_d = ST_WR;
                        end
                        OP_BURST: begin
                            a_d     = word_addr(cmd_row, COL_ZERO);
                            state_d = ST_BURST;
                        end
                        OP_FILL: begin
                            a_d     = word_addr(cmd_row, COL_ZERO);
                            din_d   = cmd_wdata;
                            we_d    = bank_onehot(cmd_row);
                            state_d = ST_FILL;
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_WR: begin
                state_d = ST_IDLE;
            end

            // The output register is guaranteed empty here: commands are only accepted with rd_valid low.
            ST_RD: begin
                rd_data_d  = dout;
                rd_valid_d = 1'b1;
                rd_last_d  = 1'b1;
                state_d    = ST_IDLE;
            end

            ST_BURST: begin
                if (beat_load_s) begin
                    rd_data_d  = dout;
                    rd_valid_d = 1'b1;
                    rd_last_d  = (col_q == COL_LAST);
                    if (col_q == COL_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        col_d = col_next_s;
                        a_d   = {a_q[A_W-1:COL_W], col_next_s};
                    end
                end else begin
                    state_d = ST_BURST;
                end
            end

            ST_FILL: begin
                if (col_q == COL_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    we_d  = we_q;
                    col_d = col_next_s;
                    a_d   = {a_q[A_W-1:COL_W], col_next_s};
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight command and write pulse.
    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            state_q    <= ST_IDLE;
            col_q      <= COL_ZERO;
            ram_sel_q  <= SEL_RST;
            a_q        <= {A_W{1'b0}};
            din_q      <= {DATA_W{1'b0}};
            we_q       <= {NRAM{1'b0}};
            rd_valid_q <= 1'b0;
            rd_data_q  <= {DATA_W{1'b0}};
            rd_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            ram_sel_q  <= ram_sel_d;
            a_q        <= a_d;
            din_q      <= din_d;
            we_q       <= we_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_last_q  <= rd_last_d;
        end
    end

    assign cmd_ready = cmd_ready_s;
    assign busy      = (state_q != ST_IDLE);
    assign ram_sel   = ram_sel_q;
    assign a         = a_q;
    assign din       = din_q;
    assign we        = we_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign rd_last   = rd_last_q;

endmodule
